// File: rtl/ring_inject_arbiter.sv
// Output-link arbiter for one ring node: pass-through FIFO vs local request/reply FIFOs.
// Latency: pop is combinational; out_vld/out_sel/out_ctrl follow pop by one cycle.
// Backpressure: per-class downstream credit gates every pop; a locked packet stalls, never aborts.
module ring_inject_arbiter #(
  parameter int SLOT_LIMIT = 14,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] src_vld,
  input  logic [1:0] src_ctrl0,
  input  logic [1:0] src_ctrl1,
  input  logic [1:0] src_ctrl2,
  input  logic [2:0] src_cls,
  input  logic       en_pass_req_in,
  input  logic       en_pass_rep_in,
  input  logic [3:0] used_slots_pass_req_in,
  input  logic [3:0] used_slots_pass_rep_in,
  output logic [2:0] pop,
  output logic       out_vld,
  output logic [1:0] out_sel,
  output logic [1:0] out_ctrl,
  output logic       busy,
  output logic       proto_err
);

  localparam logic [3:0]       SLOT_LIM_W   = 4'(SLOT_LIMIT);
  localparam logic [CNT_W-1:0] STARVE_MAX_W = CNT_W'(STARVE_MAX);

  localparam logic [1:0] CTRL_NONE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             err_q, err_d;
  logic             out_vld_q;
  logic [1:0]       out_sel_q;
  logic [1:0]       out_ctrl_q;

  logic [2:0][1:0]  ctrl_a;
  logic [2:0][1:0]  cand;
  logic [2:0]       elig;
  logic [2:0]       pop_c;
  logic [1:0]       pop_idx;
  logic             req_ok, rep_ok;
  logic             local_wait;
  logic             gnt_vld, err_hit, seen;
  logic [1:0]       gnt_idx, c;

  assign ctrl_a[0] = src_ctrl0;
  assign ctrl_a[1] = src_ctrl1;
  assign ctrl_a[2] = src_ctrl2;

  assign req_ok = en_pass_req_in && (used_slots_pass_req_in < SLOT_LIM_W);
  assign rep_ok = en_pass_rep_in && (used_slots_pass_rep_in < SLOT_LIM_W);

  // Per-source eligibility: head present and its class has downstream room.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i] = src_vld[i] && (src_cls[i] ? rep_ok : req_ok);
    end
  end

  assign local_wait = (src_vld[1] && src_ctrl1 == CTRL_HEAD) ||
                      (src_vld[2] && src_ctrl2 == CTRL_HEAD);

  // Candidate order: pass first unless locals have been starved, locals in rr order.
  always_comb begin
    cand = '0;
    if (starve_q == STARVE_MAX_W) begin
      cand[0] = rr_q ? 2'd2 : 2'd1;
      cand[1] = rr_q ? 2'd1 : 2'd2;
      cand[2] = 2'd0;
    end else begin
      cand[0] = 2'd0;
      cand[1] = rr_q ? 2'd2 : 2'd1;
      cand[2] = rr_q ? 2'd1 : 2'd2;
    end
  end

  // IDLE grant search: first eligible head wins; a body/tail on the first eligible is an error.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    err_hit = 1'b0;
    seen    = 1'b0;
    c       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      c = cand[k[1:0]];
      if (!gnt_vld && elig[c]) begin
        if (ctrl_a[c] == CTRL_HEAD) begin
          gnt_vld = 1'b1;
          gnt_idx = c;
        end else if (!seen && ctrl_a[c][1]) begin
          err_hit = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  // Next-state, pop and fairness bookkeeping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    err_d    = err_q;
    pop_c    = '0;
    case (state_q)
      IDLE: begin
        if (err_hit) err_d = 1'b1;
        if (gnt_vld) begin
          pop_c[gnt_idx] = 1'b1;
          state_d        = LOCK;
          owner_d        = gnt_idx;
          if (gnt_idx == 2'd0) begin
            if (local_wait && starve_q != STARVE_MAX_W) starve_d = starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      LOCK: begin
        if (elig[owner_q] && ctrl_a[owner_q] != CTRL_NONE) begin
          pop_c[owner_q] = 1'b1;
          if (ctrl_a[owner_q] == CTRL_TAIL) begin
            state_d = IDLE;
            owner_d = 2'd0;
            if (owner_q != 2'd0) rr_d = ~rr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_idx = pop_c[2] ? 2'd2 : (pop_c[1] ? 2'd1 : 2'd0);

  // State and registered link outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      rr_q       <= 1'b0;
      starve_q   <= '0;
      err_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_sel_q  <= 2'd0;
      out_ctrl_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
      out_vld_q <= |pop_c;
      if (|pop_c) begin
        out_sel_q  <= pop_idx;
        out_ctrl_q <= ctrl_a[pop_idx];
      end else begin
        out_ctrl_q <= 2'd0;
      end
    end
  end

  assign pop       = rst ? pop_c : 3'b000;
  assign out_vld   = out_vld_q;
  assign out_sel   = out_sel_q;
  assign out_ctrl  = out_ctrl_q;
  assign busy      = (state_q == LOCK);
  assign proto_err = err_q;

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// Directed bench for ring_inject_arbiter: reset, packet lock, starvation, credit, rr, protocol.
// Inputs change 1ns after the rising edge; pop is checked 1ns later, registered outputs after the edge.
module tb_ring_inject_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] src_vld = '0;
  logic [1:0] src_ctrl0 = '0;
  logic [1:0] src_ctrl1 = '0;
  logic [1:0] src_ctrl2 = '0;
  logic [2:0] src_cls = '0;
  logic       en_pass_req_in = 1'b1;
  logic       en_pass_rep_in = 1'b1;
  logic [3:0] used_slots_pass_req_in = '0;
  logic [3:0] used_slots_pass_rep_in = '0;
  logic [2:0] pop;
  logic       out_vld;
  logic [1:0] out_sel;
  logic [1:0] out_ctrl;
  logic       busy;
  logic       proto_err;

  int total  = 0;
  int passed = 0;

  ring_inject_arbiter dut (
    .clk(clk), .rst(rst),
    .src_vld(src_vld), .src_ctrl0(src_ctrl0), .src_ctrl1(src_ctrl1), .src_ctrl2(src_ctrl2),
    .src_cls(src_cls), .en_pass_req_in(en_pass_req_in), .en_pass_rep_in(en_pass_rep_in),
    .used_slots_pass_req_in(used_slots_pass_req_in),
    .used_slots_pass_rep_in(used_slots_pass_rep_in),
    .pop(pop), .out_vld(out_vld), .out_sel(out_sel), .out_ctrl(out_ctrl),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    src_vld = '0; src_ctrl0 = '0; src_ctrl1 = '0; src_ctrl2 = '0; src_cls = '0;
    en_pass_req_in = 1'b1; en_pass_rep_in = 1'b1;
    used_slots_pass_req_in = '0; used_slots_pass_rep_in = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    src_vld = 3'b111; src_ctrl0 = 2'b01; src_ctrl1 = 2'b01; src_ctrl2 = 2'b01; src_cls = '0;
    tick();
    total++; if (pop !== 3'b000) $display("FAIL rst_pop got=%b exp=000", pop); else passed++;
    total++; if ({out_vld, out_sel, out_ctrl, busy, proto_err} !== 7'b0)
      $display("FAIL rst_outs got=%b exp=0000000", {out_vld, out_sel, out_ctrl, busy, proto_err});
    else passed++;
    rst = 1'b1;
    #1;
    total++; if (pop !== 3'b001) $display("FAIL rst_release_pop got=%b exp=001", pop); else passed++;
    tick();
    total++; if ({out_vld, out_sel, out_ctrl, busy} !== 6'b1_00_01_1)
      $display("FAIL rst_first_grant got=%b exp=100011", {out_vld, out_sel, out_ctrl, busy});
    else passed++;
    src_ctrl0 = 2'b10;
    rst = 1'b0;
    #1;
    total++; if ({busy, pop} !== 4'b0000)
      $display("FAIL rst_midpacket got=%b exp=0000", {busy, pop}); else passed++;
  endtask

  task automatic test_pass_packet();
    logic [1:0] seq [3];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
    do_reset();
    src_vld = 3'b001;
    for (int i = 0; i < 3; i++) begin
      src_ctrl0 = seq[i];
      #1;
      total++; if (pop !== 3'b001) $display("FAIL pass_pop%0d got=%b exp=001", i, pop); else passed++;
      tick();
      total++; if ({out_vld, out_sel, out_ctrl} !== {1'b1, 2'd0, seq[i]})
        $display("FAIL pass_out%0d got=%b exp=%b", i, {out_vld, out_sel, out_ctrl}, {1'b1, 2'd0, seq[i]});
      else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL pass_busy_end got=%b exp=0", busy); else passed++;
    src_vld = 3'b000;
    #1;
    total++; if (pop !== 3'b000) $display("FAIL pass_idle_pop got=%b exp=000", pop); else passed++;
    tick();
    total++; if ({out_vld, out_ctrl} !== 3'b000)
      $display("FAIL pass_idle_out got=%b exp=000", {out_vld, out_ctrl}); else passed++;
  endtask

  task automatic test_starvation();
    do_reset();
    src_vld = 3'b011; src_ctrl1 = 2'b01;
    for (int p = 0; p < 8; p++) begin
      src_ctrl0 = 2'b01;
      #1;
      total++; if (pop !== 3'b001) $display("FAIL starve_head%0d got=%b exp=001", p, pop); else passed++;
      tick();
      src_ctrl0 = 2'b11;
      #1;
      total++; if (pop !== 3'b001) $display("FAIL starve_tail%0d got=%b exp=001", p, pop); else passed++;
      tick();
    end
    src_ctrl0 = 2'b01;
    #1;
    total++; if (pop !== 3'b010) $display("FAIL starve_forced got=%b exp=010", pop); else passed++;
    tick();
    total++; if ({out_sel, busy} !== 3'b01_1)
      $display("FAIL starve_forced_out got=%b exp=011", {out_sel, busy}); else passed++;
    src_ctrl1 = 2'b11;
    #1;
    total++; if (pop !== 3'b010) $display("FAIL starve_ltail got=%b exp=010", pop); else passed++;
    tick();
    src_ctrl1 = 2'b01;
    #1;
    total++; if (pop !== 3'b001) $display("FAIL starve_cleared got=%b exp=001", pop); else passed++;
  endtask

  task automatic test_credit();
    do_reset();
    src_vld = 3'b001; src_ctrl0 = 2'b01; src_cls = 3'b010;
    #1;
    total++; if (pop !== 3'b001) $display("FAIL cred_head got=%b exp=001", pop); else passed++;
    tick();
    src_ctrl0 = 2'b10; used_slots_pass_req_in = 4'd14;
    src_vld = 3'b011; src_ctrl1 = 2'b01;
    #1;
    total++; if (pop !== 3'b000) $display("FAIL cred_stall_pop got=%b exp=000", pop); else passed++;
    tick();
    total++; if ({out_vld, out_ctrl, busy} !== 4'b0_00_1)
      $display("FAIL cred_stall_out got=%b exp=0001", {out_vld, out_ctrl, busy}); else passed++;
    used_slots_pass_req_in = 4'd13;
    #1;
    total++; if (pop !== 3'b001) $display("FAIL cred_resume_pop got=%b exp=001", pop); else passed++;
    tick();
    total++; if ({out_vld, out_sel, out_ctrl} !== 5'b1_00_10)
      $display("FAIL cred_resume_out got=%b exp=10010", {out_vld, out_sel, out_ctrl}); else passed++;
    src_ctrl0 = 2'b11;
    #1;
    total++; if (pop !== 3'b001) $display("FAIL cred_tail got=%b exp=001", pop); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL cred_busy_end got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_pop [3];
    logic [1:0] exp_sel [3];
    exp_pop[0] = 3'b010; exp_pop[1] = 3'b100; exp_pop[2] = 3'b010;
    exp_sel[0] = 2'd1;   exp_sel[1] = 2'd2;   exp_sel[2] = 2'd1;
    do_reset();
    src_cls = 3'b100;
    for (int n = 0; n < 3; n++) begin
      src_vld = 3'b110; src_ctrl1 = 2'b01; src_ctrl2 = 2'b01;
      #1;
      total++; if (pop !== exp_pop[n]) $display("FAIL rr_head%0d got=%b exp=%b", n, pop, exp_pop[n]); else passed++;
      tick();
      if (exp_sel[n] == 2'd1) src_ctrl1 = 2'b11; else src_ctrl2 = 2'b11;
      #1;
      total++; if (pop !== exp_pop[n]) $display("FAIL rr_tail%0d got=%b exp=%b", n, pop, exp_pop[n]); else passed++;
      tick();
      total++; if ({out_sel, out_ctrl, busy} !== {exp_sel[n], 2'b11, 1'b0})
        $display("FAIL rr_out%0d got=%b exp=%b", n, {out_sel, out_ctrl, busy}, {exp_sel[n], 2'b11, 1'b0});
      else passed++;
      if (n == 1) begin
        src_vld = 3'b000;
        tick();
        total++; if ({out_vld, out_sel} !== 3'b0_10)
          $display("FAIL rr_sel_hold got=%b exp=010", {out_vld, out_sel}); else passed++;
      end
    end
    used_slots_pass_rep_in = 4'd14;
    src_vld = 3'b110; src_ctrl1 = 2'b01; src_ctrl2 = 2'b01;
    #1;
    total++; if (pop !== 3'b010) $display("FAIL rr_rep_blocked got=%b exp=010", pop); else passed++;
  endtask

  task automatic test_protocol();
    do_reset();
    src_cls = 3'b000;
    src_vld = 3'b110; src_ctrl1 = 2'b10; src_ctrl2 = 2'b01;
    #1;
    total++; if (pop !== 3'b100) $display("FAIL proto_skip got=%b exp=100", pop); else passed++;
    tick();
    total++; if ({proto_err, busy, out_sel} !== 4'b1_1_10)
      $display("FAIL proto_set got=%b exp=1110", {proto_err, busy, out_sel}); else passed++;
    src_vld = 3'b100; src_ctrl2 = 2'b11;
    tick();
    src_vld = 3'b000;
    tick();
    tick();
    total++; if ({proto_err, busy} !== 2'b10)
      $display("FAIL proto_sticky got=%b exp=10", {proto_err, busy}); else passed++;
    do_reset();
    total++; if (proto_err !== 1'b0) $display("FAIL proto_clear got=%b exp=0", proto_err); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_pass_packet();
    test_starvation();
    test_credit();
    test_round_robin();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
